// File: rtl/load_pkg.sv
// Shared definitions for the load sequencer and the dataload stage it feeds:
// FSM state type, load-type encodings, default geometry and a width helper.
package load_pkg;

   // Default tile geometry: one weight word, eight 32-bit input words.
   localparam int W_WORDS_DEF = 1;
   localparam int I_WORDS_DEF = 8;
   localparam int TILE_W_DEF  = 8;

   // Encoding of dataload's load_type input.
   localparam logic LOAD_TYPE_WEIGHT = 1'b0;
   localparam logic LOAD_TYPE_INPUT  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_I,
      S_WAIT_ACK,
      S_DONE
   } seq_state_t;

   // Bits needed to hold values 0..max_val, never fewer than one.
   function automatic int cnt_width(input int max_val);
      return (max_val <= 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/load_word_cnt.sv
// Up-counter with synchronous clear, increment and a terminal-count flag
// that compares against a runtime last value. Clear wins over increment.
module load_word_cnt #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [WIDTH-1:0] i_last,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_term
);

   logic [WIDTH-1:0] r_cnt;

   // Count register: clear has priority, otherwise step on increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_term = (r_cnt == i_last);

endmodule

// File: rtl/load_sequencer.sv
// Upstream feeder for the dataload stage. Takes a 32-bit host word stream
// over valid/ready and drives dataload tile by tile: W_WORDS weight words,
// then I_WORDS input words, then waits for tile_ack_i before the next tile.
// Optional build macro LOAD_SEQ_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of load-state cycles in which the host had no word available.
module load_sequencer
   import load_pkg::*;
#(
   parameter int W_WORDS = W_WORDS_DEF,
   parameter int I_WORDS = I_WORDS_DEF,
   parameter int TILE_W  = TILE_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [TILE_W-1:0] num_tiles_i,
   input  logic [31:0]       host_data_i,
   input  logic              host_valid_i,
   output logic              host_ready_o,
   input  logic              tile_ack_i,
   output logic [31:0]       data_o,
   output logic              load_en_o,
   output logic              load_type_o,
   output logic [TILE_W-1:0] tile_idx_o,
   output logic              busy_o,
   output logic              done_o
`ifdef LOAD_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt_o
`endif
);

   localparam int WC_MAX = ((W_WORDS > I_WORDS) ? W_WORDS : I_WORDS) - 1;
   localparam int WC_W   = cnt_width(WC_MAX);

   seq_state_t        r_state;
   logic [TILE_W-1:0] r_num_tiles;
   logic [31:0]       r_data;
   logic              r_load_en;
   logic              r_load_type;

   logic              w_hs;
   logic              w_start;
   logic [WC_W-1:0]   w_word_last;
   logic [WC_W-1:0]   w_word_cnt_unused;
   logic              w_word_term;
   logic              w_tile_term;
   logic              w_tile_inc;
   logic [TILE_W-1:0] w_tile_last;

   // Ready is a pure decode of the registered state, independent of valid.
   assign host_ready_o = (r_state == S_LOAD_W) || (r_state == S_LOAD_I);
   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = (r_state == S_DONE);

   assign w_hs        = host_valid_i & host_ready_o;
   assign w_start     = start_i & (r_state == S_IDLE);
   assign w_word_last = (r_state == S_LOAD_I) ? WC_W'(I_WORDS - 1)
                                              : WC_W'(W_WORDS - 1);
   assign w_tile_last = r_num_tiles - TILE_W'(1);
   assign w_tile_inc  = (r_state == S_WAIT_ACK) & tile_ack_i & ~w_tile_term;

   // Word position within the current weight or input phase.
   load_word_cnt #(.WIDTH(WC_W)) u_word_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_start | (w_hs & w_word_term)),
      .i_inc  (w_hs),
      .i_last (w_word_last),
      .o_cnt  (w_word_cnt_unused),
      .o_term (w_word_term)
   );

   // Tile index within the job; terminal when the last tile is reached.
   load_word_cnt #(.WIDTH(TILE_W)) u_tile_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_start),
      .i_inc  (w_tile_inc),
      .i_last (w_tile_last),
      .o_cnt  (tile_idx_o),
      .o_term (w_tile_term)
   );

   // Sequencing FSM plus the registered dataload drive (data, enable, type).
   // NOTE: non-blocking assignments make every register here sample the
   // pre-edge values, so state and outputs update together without races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_num_tiles <= '0;
         r_data      <= '0;
         r_load_en   <= 1'b0;
         r_load_type <= LOAD_TYPE_WEIGHT;
      end else begin
         r_load_en <= w_hs;
         if (w_hs) begin
            r_data      <= host_data_i;
            r_load_type <= (r_state == S_LOAD_I) ? LOAD_TYPE_INPUT
                                                 : LOAD_TYPE_WEIGHT;
         end

         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_num_tiles <= num_tiles_i;
                  r_state     <= (num_tiles_i != '0) ? S_LOAD_W : S_DONE;
               end
            end
            S_LOAD_W: begin
               if (w_hs && w_word_term) r_state <= S_LOAD_I;
            end
            S_LOAD_I: begin
               if (w_hs && w_word_term) r_state <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (tile_ack_i) r_state <= w_tile_term ? S_DONE : S_LOAD_W;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign data_o      = r_data;
   assign load_en_o   = r_load_en;
   assign load_type_o = r_load_type;

`ifdef LOAD_SEQ_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Host starvation counter: loading states with no valid word, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_start) begin
         r_stall_cnt <= '0;
      end else if (host_ready_o && !host_valid_i && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_load_sequencer.sv
// Self-checking bench for load_sequencer. The driver pushes the expected
// dataload write for every host word it offers; a separate monitor pops and
// compares on each load_en_o. Control timing is checked inline by the driver.
module tb_load_sequencer;
   import load_pkg::*;

   localparam int TILE_W     = 8;
   localparam int W_WORDS    = 1;
   localparam int I_WORDS    = 8;
   localparam int TILE_WORDS = W_WORDS + I_WORDS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic [TILE_W-1:0] num_tiles_i = '0;
   logic [31:0]       host_data_i = '0;
   logic              host_valid_i = 1'b0;
   logic              host_ready_o;
   logic              tile_ack_i = 1'b0;
   logic [31:0]       data_o;
   logic              load_en_o;
   logic              load_type_o;
   logic [TILE_W-1:0] tile_idx_o;
   logic              busy_o;
   logic              done_o;
`ifdef LOAD_SEQ_STALL_CNT_EN
   logic [15:0]       stall_cnt_o;
`endif

   load_sequencer #(
      .W_WORDS (W_WORDS),
      .I_WORDS (I_WORDS),
      .TILE_W  (TILE_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .num_tiles_i  (num_tiles_i),
      .host_data_i  (host_data_i),
      .host_valid_i (host_valid_i),
      .host_ready_o (host_ready_o),
      .tile_ack_i   (tile_ack_i),
      .data_o       (data_o),
      .load_en_o    (load_en_o),
      .load_type_o  (load_type_o),
      .tile_idx_o   (tile_idx_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
`ifdef LOAD_SEQ_STALL_CNT_EN
      ,
      .stall_cnt_o  (stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       data;
      logic              ltype;
      logic [TILE_W-1:0] tile;
   } exp_t;

   exp_t exp_q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   loads_seen = 0;
   int   total_gaps = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every dataload write must match the oldest offered word.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && load_en_o) begin
            loads_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_load: got data %0h tile %0d expected no load",
                        data_o, tile_idx_o);
            end else begin
               e = exp_q.pop_front();
               check("load_data", 64'(data_o), 64'(e.data));
               check("load_type", 64'(load_type_o), 64'(e.ltype));
               check("load_tile", 64'(tile_idx_o), 64'(e.tile));
            end
         end
      end
   end

   // Offer one word after `gap` idle cycles and hold it until accepted.
   task automatic send_word(input logic [31:0] d, input int gap,
                            input logic [TILE_W-1:0] tile, input logic ltype,
                            input bit inj_start, input bit inj_ack);
      bit hs;
      int n;
      host_valid_i = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      total_gaps += gap;
      exp_q.push_back('{data: d, ltype: ltype, tile: tile});
      host_valid_i = 1'b1;
      host_data_i  = d;
      if (inj_start) begin
         start_i     = 1'b1;
         num_tiles_i = '0;
      end
      if (inj_ack) tile_ack_i = 1'b1;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 64) begin
         @(negedge clk);
         hs = host_ready_o;
         @(posedge clk);
         #1;
         start_i    = 1'b0;
         tile_ack_i = 1'b0;
         n++;
      end
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL hs_timeout: got no handshake in 64 cycles expected acceptance");
      end
   endtask

   // One job. gap_mode: 0 back-to-back, 1 toggle, 2 random, 3 five-cycle gap
   // before word 3. Injections index the word count across the job; a job
   // with abort_after > 0 returns right after that many words.
   task automatic run_job(input int n_tiles, input int gap_mode, input bit seq,
                          input int inj_start_k, input int inj_ack_k,
                          input int abort_after);
      int loads0;
      int gk;
      int g;
      logic [31:0] d;
      loads0      = loads_seen;
      total_gaps  = 0;
      start_i     = 1'b1;
      num_tiles_i = TILE_W'(n_tiles);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check("start_busy", 64'(busy_o), 64'd1);
      check("start_ready", 64'(host_ready_o), 64'(n_tiles != 0));
`ifdef LOAD_SEQ_STALL_CNT_EN
      check("stall_clear", 64'(stall_cnt_o), 64'd0);
`endif
      if (n_tiles == 0) begin
         check("zero_done", 64'(done_o), 64'd1);
         @(posedge clk);
         #1;
         check("zero_done_end", 64'({done_o, busy_o}), 64'd0);
         repeat (3) @(posedge clk);
         #1;
         check("zero_loads", 64'(loads_seen - loads0), 64'd0);
         return;
      end
      gk = 0;
      for (int t = 0; t < n_tiles; t++) begin
         check("tile_idx", 64'(tile_idx_o), 64'(t));
         for (int k = 0; k < TILE_WORDS; k++) begin
            case (gap_mode)
               0:       g = 0;
               1:       g = 1;
               2:       g = $urandom_range(0, 2);
               default: g = (k == 3) ? 5 : 0;
            endcase
            d = seq ? 32'h100 + 32'(gk) : $urandom;
            send_word(d, g, TILE_W'(t), (k >= W_WORDS) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT,
                      gk == inj_start_k, gk == inj_ack_k);
            gk++;
            if (abort_after > 0 && gk == abort_after) return;
         end
         // Waiting for the ack: a word stays offered but must not be taken.
         host_valid_i = 1'b1;
         host_data_i  = 32'hBAD0_0000 | 32'(t);
         repeat (3) begin
            @(negedge clk);
            check("wait_ready_low", 64'(host_ready_o), 64'd0);
            @(posedge clk);
            #1;
         end
`ifdef LOAD_SEQ_STALL_CNT_EN
         check("stall_cnt", 64'(stall_cnt_o), 64'(total_gaps));
`endif
         tile_ack_i = 1'b1;
         @(posedge clk);
         #1;
         tile_ack_i   = 1'b0;
         host_valid_i = 1'b0;
         if (t < n_tiles - 1) begin
            check("ack_ready", 64'(host_ready_o), 64'd1);
         end else begin
            check("final_done", 64'({done_o, busy_o}), 64'b11);
            @(posedge clk);
            #1;
            check("final_idle", 64'({done_o, busy_o}), 64'd0);
         end
      end
      @(posedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("load_count", 64'(loads_seen - loads0), 64'(n_tiles * TILE_WORDS));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      // Reset, then idle with a valid host word held the whole time.
      host_valid_i = 1'b1;
      host_data_i  = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("idle_outputs", 64'({data_o, load_en_o, load_type_o, host_ready_o,
                                     tile_idx_o, busy_o, done_o}), 64'd0);
      end
      host_valid_i = 1'b0;
      @(posedge clk);
      #1;

      // Single tile, sequential data, back-to-back.
      run_job(1, 0, 1'b1, -1, -1, 0);
      // Three tiles, valid toggling, stray ack in LOAD_I and stray start in LOAD_W.
      run_job(3, 1, 1'b0, TILE_WORDS, 3, 0);
      // Empty job.
      run_job(0, 0, 1'b0, -1, -1, 0);
      // Five-cycle host stall inside the input phase.
      run_job(1, 3, 1'b0, -1, -1, 0);

      // Reset after four words of tile 1.
      run_job(2, 2, 1'b0, -1, -1, TILE_WORDS + 4);
      host_valid_i = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_outputs", 64'({data_o, load_en_o, load_type_o, host_ready_o,
                                   tile_idx_o, busy_o, done_o}), 64'd0);
      check("reset_queue", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_job(1, 0, 1'b1, -1, -1, 0);

      // Randomised jobs.
      for (int j = 0; j < 3; j++) begin
         run_job($urandom_range(1, 4), 2, 1'b0, -1, -1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
